// File: rtl/cipher_burst_if_ctrl_if.sv
// Host/core-facing handshake bundle for the cipher burst controller.
// Signal prefixes are from the controller's point of view.
interface cipher_burst_if_ctrl_if #(
    parameter int unsigned BLOCK_BYTES = 4,
    parameter int unsigned CNT_W       = 8
);
    localparam int unsigned IDX_W = $clog2(BLOCK_BYTES);

    logic             i_input_request;
    logic             i_input_valid;
    logic             i_output_is_ready;
    logic             i_output_acknowledge;
    logic             i_abort;
    logic [2:0]       o_state_out;
    logic [IDX_W-1:0] o_byte_index;
    logic             o_load_en;
    logic             o_start_pulse;
    logic             o_output_valid;
    logic             o_busy;
    logic             o_timeout_flag;
    logic [CNT_W-1:0] o_blocks_done;

    modport slave (
        input  i_input_request, i_input_valid, i_output_is_ready, i_output_acknowledge, i_abort,
        output o_state_out, o_byte_index, o_load_en, o_start_pulse, o_output_valid, o_busy,
        o_timeout_flag, o_blocks_done
    );

    modport master (
        output i_input_request, i_input_valid, i_output_is_ready, i_output_acknowledge, i_abort,
        input  o_state_out, o_byte_index, o_load_en, o_start_pulse, o_output_valid, o_busy,
        o_timeout_flag, o_blocks_done
    );
endinterface

// File: rtl/cipher_burst_if_ctrl.sv
// Load / process / drain sequencer for one cipher block, with stall timeout,
// synchronous abort and a wrapping completed-block counter.
module cipher_burst_if_ctrl #(
    parameter int unsigned BLOCK_BYTES    = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned CNT_W          = 8
) (
    input  logic                  clk,
    input  logic                  nrst,
    cipher_burst_if_ctrl_if.slave io_bus
);
    localparam int unsigned IDX_W  = $clog2(BLOCK_BYTES);
    // Counter only has to reach TIMEOUT_CYCLES-1; the next stall fires the error.
    localparam int unsigned TCNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(BLOCK_BYTES - 1);
    localparam logic [TCNT_W-1:0] TCNT_LAST =
        TCNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StLoad  = 3'd1,
        StProc  = 3'd2,
        StDrain = 3'd3,
        StError = 3'd4
    } t_state;

    t_state             r_state;
    t_state             w_state_d;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   w_idx_d;
    logic [TCNT_W-1:0]  r_tcnt;
    logic [TCNT_W-1:0]  w_tcnt_d;
    logic               r_tflag;
    logic               r_start;
    logic [CNT_W-1:0]   r_blocks;
    logic               w_busy;
    logic               w_progress;
    logic               w_timeout_hit;
    logic               w_block_done;

    // State register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Next-state decode: abort, then progress, then timeout, else hold
    always_comb begin
        w_state_d = r_state;
        if (io_bus.i_abort) begin
            w_state_d = StIdle;
        end else begin
            case (r_state)
                StIdle:  if (io_bus.i_input_request) w_state_d = StLoad;
                StLoad: begin
                    if (io_bus.i_input_valid && r_idx == IDX_LAST) w_state_d = StProc;
                    else if (w_timeout_hit)                       w_state_d = StError;
                end
                StProc: begin
                    if (io_bus.i_output_is_ready) w_state_d = StDrain;
                    else if (w_timeout_hit)       w_state_d = StError;
                end
                StDrain: begin
                    if (io_bus.i_output_acknowledge && r_idx == IDX_LAST) w_state_d = StIdle;
                    else if (w_timeout_hit)                              w_state_d = StError;
                end
                StError: w_state_d = StError;
                default: w_state_d = StIdle;
            endcase
        end
    end

    // Combinational outputs and per-cycle status decode
    always_comb begin
        w_busy        = (r_state == StLoad) || (r_state == StProc) || (r_state == StDrain);
        w_progress    = ((r_state == StLoad)  && io_bus.i_input_valid)
                     || ((r_state == StProc)  && io_bus.i_output_is_ready)
                     || ((r_state == StDrain) && io_bus.i_output_acknowledge);
        w_timeout_hit = (TIMEOUT_CYCLES != 0) && w_busy && !w_progress && (r_tcnt == TCNT_LAST);
        w_block_done  = (r_state == StDrain) && io_bus.i_output_acknowledge
                     && (r_idx == IDX_LAST) && !io_bus.i_abort;
        io_bus.o_load_en      = (r_state == StLoad) && io_bus.i_input_valid;
        io_bus.o_output_valid = (r_state == StDrain);
        io_bus.o_busy         = w_busy;
    end

    // Next byte slot and stall count; both restart on any state change
    always_comb begin
        w_idx_d  = r_idx;
        w_tcnt_d = r_tcnt;
        if (io_bus.i_abort || w_state_d != r_state) begin
            w_idx_d = '0;
        end else if (w_progress) begin
            w_idx_d = r_idx + IDX_W'(1);
        end
        if (TIMEOUT_CYCLES == 0 || io_bus.i_abort || w_state_d != r_state
            || w_progress || !w_busy) begin
            w_tcnt_d = '0;
        end else begin
            w_tcnt_d = r_tcnt + TCNT_W'(1);
        end
    end

    // Datapath registers: index, stall counter, flags, block counter
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_idx    <= '0;
            r_tcnt   <= '0;
            r_tflag  <= 1'b0;
            r_start  <= 1'b0;
            r_blocks <= '0;
        end else begin
            r_idx   <= w_idx_d;
            r_tcnt  <= w_tcnt_d;
            r_start <= (w_state_d == StProc) && (r_state != StProc);
            if (io_bus.i_abort)     r_tflag <= 1'b0;
            else if (w_timeout_hit) r_tflag <= 1'b1;
            if (w_block_done)       r_blocks <= r_blocks + CNT_W'(1);
        end
    end

    assign io_bus.o_state_out    = r_state;
    assign io_bus.o_byte_index   = r_idx;
    assign io_bus.o_start_pulse  = r_start;
    assign io_bus.o_timeout_flag = r_tflag;
    assign io_bus.o_blocks_done  = r_blocks;
endmodule

// File: doc/cipher_burst_if_ctrl.md
Name: cipher_burst_if_ctrl

Overview:
Next-generation chip-level handshake controller for the stream cipher datapath. It sequences a multi-byte block through the load, processing and output-drain phases. It adds per-byte load/drain counting, a stall timeout with an error state, a synchronous abort, and a completed-block counter. It sits between the chip input pins and the cipher core / output holder, and drives their enables and byte indices.

Parameters:
BLOCK_BYTES, 4, bytes per cipher block, loaded and drained one byte per handshake; must be >= 2.
TIMEOUT_CYCLES, 64, consecutive stall cycles in a busy state before entering ERROR; 0 disables the timeout.
CNT_W, 8, width of the blocks_done counter.

Ports:
clk  input  1  clock
nrst  input  1  asynchronous active-low reset
input_request  input  1  host requests a new block (level)
input_valid  input  1  host byte strobe during LOAD
output_is_ready  input  1  cipher core or output holder has the result
output_acknowledge  input  1  host consumed the presented output byte
abort  input  1  synchronous abort/clear, single-cycle pulse or level
state_out  output  3  IDLE=0, LOAD=1, PROCESSING=2, DRAIN=3, ERROR=4
byte_index  output  $clog2(BLOCK_BYTES)  current byte slot for load or drain
load_en  output  1  write enable for the input byte register at byte_index
start_pulse  output  1  one-cycle core start
output_valid  output  1  output byte at byte_index is presented
busy  output  1  state is LOAD, PROCESSING or DRAIN
timeout_flag  output  1  sticky timeout error
blocks_done  output  CNT_W  completed-block count, wraps

Behaviour:
Reset and mode:
- Reset (async, nrst=0): state IDLE, byte_index 0, timeout counter 0, blocks_done 0, timeout_flag 0, start_pulse 0.
- Every output except load_en, output_valid and busy is registered.
- load_en is combinational: (state==LOAD && input_valid).
- output_valid is combinational: (state==DRAIN).
- busy is combinational: state in {LOAD, PROCESSING, DRAIN}.

Transitions (priority: abort > progress > timeout > hold):
- IDLE: input_request=1 -> LOAD next cycle, byte_index=0.
- LOAD: each cycle with input_valid=1 is a progress event and increments byte_index. When byte_index==BLOCK_BYTES-1 and input_valid=1 -> PROCESSING and byte_index=0.
- start_pulse is high for exactly the first PROCESSING cycle.
- PROCESSING: output_is_ready=1 (progress) -> DRAIN, byte_index=0.
- DRAIN: output_acknowledge=1 (progress) increments byte_index. On acknowledge at byte_index==BLOCK_BYTES-1 -> IDLE, byte_index=0, blocks_done+1 modulo 2^CNT_W.
- ERROR: holds until abort. timeout_flag stays 1 in ERROR.
- abort=1 in any state -> IDLE next cycle; clears byte_index, timeout counter and timeout_flag. blocks_done is preserved.

Ignored inputs:
- input_valid outside LOAD.
- output_is_ready outside PROCESSING.
- output_acknowledge outside DRAIN.
- input_request outside IDLE.
- input_request still high on return to IDLE starts a new block on the next cycle; back-to-back blocks are allowed.

Timeout:
- The counter clears on every progress event and every state change.
- It increments on each busy-state cycle with no progress.
- When it reaches TIMEOUT_CYCLES (i.e. TIMEOUT_CYCLES consecutive stall cycles), the state is ERROR on the next edge and timeout_flag=1.
- A progress event in the same cycle as the threshold wins: no error.
- TIMEOUT_CYCLES=0: the counter is held at 0 and ERROR is unreachable.

Reset mid-operation:
- Asserting nrst in any state returns to reset values immediately, with no pending start_pulse.

Test Plan:
- Reset then nominal block (BLOCK_BYTES=4): input_request for 1 cycle, 4 input_valid cycles -> load_en high with byte_index 0,1,2,3; state PROCESSING with start_pulse=1 for one cycle; output_is_ready -> DRAIN; 4 acknowledges -> IDLE, blocks_done=1.
- Gapped load: input_valid pattern 1,0,0,1,1,1 -> byte_index advances only on strobes; PROCESSING entered after the 6th cycle; no timeout (TIMEOUT_CYCLES=8).
- Timeout (TIMEOUT_CYCLES=8): enter PROCESSING, hold output_is_ready=0 -> state ERROR after 8 stall cycles, timeout_flag=1; later output_is_ready ignored; abort -> IDLE, timeout_flag=0, blocks_done unchanged.
- Boundary progress: in DRAIN, acknowledge arrives exactly on the 8th stall cycle -> no ERROR, byte_index increments.
- Abort mid-DRAIN at byte_index=2 -> IDLE next cycle, byte_index=0, blocks_done unchanged; back-to-back input_request held high -> LOAD immediately after.
- Counter wrap with CNT_W=2: 5 complete blocks -> blocks_done=1. Async nrst pulse mid-LOAD -> all outputs at reset values within the same cycle.
